// File: rtl/decrementer_pkg.sv
// decrementer_pkg: shared types and constants for the multi-cycle decrementer.
// Used by decrementer4b and decrementer_xb (optional build macro DECREMENTER_SATURATE_EN
// is consumed by decrementer_xb only).
package decrementer_pkg;

  // Width of one borrow-ripple slice; one slice is processed per cycle.
  localparam int NIBBLE_W = 4;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the nibble index register; never below 1 so a single-nibble
  // build still has a legal index vector.
  function automatic int idx_width(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage : decrementer_pkg

// File: rtl/decrementer4b.sv
// decrementer4b: combinational 4-bit borrow slice, d = a - bin.
// Borrow propagates out only when a borrow comes in and the nibble is zero.
module decrementer4b
  import decrementer_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic                bin,
  output logic [NIBBLE_W-1:0] d,
  output logic                bout
);

  // Slice arithmetic; the subtraction wraps within the nibble.
  always_comb begin
    d    = a - NIBBLE_W'(bin);
    bout = bin & (a == '0);
  end

endmodule : decrementer4b

// File: rtl/decrementer_xb.sv
// decrementer_xb: multi-cycle WIDTH-bit decrementer (out = in - 1).
// Ripples a registered borrow through one nibble per cycle, LSB first, with
// valid/ready handshakes on both sides.
// Build option: define DECREMENTER_SATURATE_EN to clamp a zero operand to a
// zero result (borrow still flagged) instead of wrapping to all-ones.
module decrementer_xb
  import decrementer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_borrow,
  output logic             out_zero
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW  = idx_width(NIB);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  work_q,  work_d;
  logic              borrow_q, borrow_d;
  logic [IW-1:0]     idx_q,   idx_d;

  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_d;
  logic                slice_bout;
  logic                last_nibble;

  // Select the nibble currently being processed.
  always_comb begin
    slice_a     = work_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
    last_nibble = (idx_q == LAST_IDX);
  end

  // Single shared slice, time-multiplexed across nibbles by idx_q.
  decrementer4b u_slice (
    .a    (slice_a),
    .bin  (borrow_q),
    .d    (slice_d),
    .bout (slice_bout)
  );

  // State register.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept in IDLE, fixed-length run, hold in DONE until taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)            state_d = RUN;
      RUN:     if (last_nibble)         state_d = DONE;
      DONE:    if (out_ready)           state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Datapath next-state: load operand on accept, replace one nibble per RUN cycle.
  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    work_d   = work_q;
    borrow_d = borrow_q;
    idx_d    = idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d   = in_data;
          borrow_d = 1'b1;
          idx_d    = '0;
        end
      end
      RUN: begin
        work_d[NIBBLE_W*int'(idx_q) +: NIBBLE_W] = slice_d;
        borrow_d = slice_bout;
        if (last_nibble) begin
`ifdef DECREMENTER_SATURATE_EN
          // A borrow out of the top nibble means the operand was zero: clamp.
          if (slice_bout) begin
            work_d = '0;
          end
`endif
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; cleared on reset so a discarded run leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q   <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      work_q   <= work_d;
      borrow_q <= borrow_d;
      idx_q    <= idx_d;
    end
  end

  // Outputs decoded from registered state only; result fields read 0 outside DONE.
  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == DONE);
    out_data   = out_valid ? work_q : '0;
    out_borrow = out_valid & borrow_q;
    out_zero   = out_valid & (work_q == '0);
  end

endmodule : decrementer_xb

// File: tb/tb_decrementer_xb.sv
// tb_decrementer_xb: directed self-checking bench for decrementer_xb, WIDTH = 16.
// Honours DECREMENTER_SATURATE_EN for the underflow expectations.
module tb_decrementer_xb;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_borrow;
  logic        out_zero;

  int vectors;
  int miscompares;

  decrementer_xb #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_borrow (out_borrow),
    .out_zero   (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer op for one edge (caller ensures IDLE), then count edges until out_valid.
  task automatic run_op(input logic [15:0] op, output int lat);
    in_valid = 1'b1;
    in_data  = op;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'hDEAD;  // must not matter after the accept edge
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Full transaction: accept, check latency and result, then deliver.
  task automatic do_op(input string tag, input logic [15:0] op,
                       input logic [15:0] exp_data, input logic exp_borrow,
                       input logic exp_zero);
    int lat;
    run_op(op, lat);
    check({tag, "_latency"}, lat, 4);
    check({tag, "_data"}, out_data, exp_data);
    check({tag, "_borrow"}, out_borrow, exp_borrow);
    check({tag, "_zero"}, out_zero, exp_zero);
    check({tag, "_in_ready_busy"}, in_ready, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_back_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int lat;
    int seen;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 16'h0000;
    out_ready   = 1'b0;

    // Reset state.
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_outs", {out_valid, out_data, out_borrow, out_zero}, 19'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Main function over distinct patterns.
    do_op("basic",   16'h1234, 16'h1233, 1'b0, 1'b0);
    do_op("ripple",  16'h1000, 16'h0FFF, 1'b0, 1'b0);
    do_op("zero",    16'h0001, 16'h0000, 1'b0, 1'b1);
`ifdef DECREMENTER_SATURATE_EN
    do_op("under",   16'h0000, 16'h0000, 1'b1, 1'b1);
`else
    do_op("under",   16'h0000, 16'hFFFF, 1'b1, 1'b0);
`endif
    do_op("allones", 16'hFFFF, 16'hFFFE, 1'b0, 1'b0);
    do_op("top",     16'hF000, 16'hEFFF, 1'b0, 1'b0);

    // Backpressure: hold in DONE for 3 cycles with a competing operand offered.
    run_op(16'h0050, lat);
    check("bp_latency", lat, 4);
    in_valid = 1'b1;
    in_data  = 16'hAAAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold", {out_valid, in_ready, out_data, out_borrow, out_zero},
            {1'b1, 1'b0, 16'h004F, 1'b0, 1'b0});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release", {out_valid, in_ready}, 2'b01);
    @(negedge clk);
    check("bp_no_capture", {out_valid, in_ready}, 2'b01);

    // Reset during the second RUN cycle discards the operation.
    in_valid = 1'b1;
    in_data  = 16'h5555;
    @(negedge clk);        // accept edge E0 done
    in_valid = 1'b0;
    @(negedge clk);        // E1 done, now in 2nd RUN cycle
    rst_n = 1'b0;
    #2;
    check("mid_rst_state", {out_valid, in_ready}, 2'b01);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_rst_no_result", seen, 0);
    do_op("after_rst", 16'h0100, 16'h00FF, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_decrementer_xb
